// File: rtl/uart_pkg.sv
// Shared constants for the 32-bit word serial link (receiver and transmitter).
package uart_pkg;

   // Ticks per bit; the receiver's sample counter is sized for exactly 16.
   localparam int OVERSAMPLE = 16;

   // 8N2 frame format.
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;
   localparam int   STOP_BITS = 2;

   // Receiver state encoding.
   localparam int         STATE_W = 3;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] START   = 3'd1;
   localparam logic [2:0] DATA    = 3'd2;
   localparam logic [2:0] STOP1   = 3'd3;
   localparam logic [2:0] STOP2   = 3'd4;

   // Clock cycles per oversample tick, rounded to nearest.
   function automatic int uart_divisor(input int clk_freq, input int baud);
      int den;
      den = baud * OVERSAMPLE;
      return (clk_freq + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_word_receiver_if.sv
// Word-link receiver signal bundle: serial line in, assembled word and strobes out.
interface uart_word_receiver_if #(
   parameter int WORD_W = 32
);
   logic              RxD;
   logic [WORD_W-1:0] dataOut;
   logic              dataValid;
   logic              frameErr;
   logic              busy;

   // Line driver / word consumer side.
   modport master (
      output RxD,
      input  dataOut, dataValid, frameErr, busy
   );

   // Receiver side.
   modport slave (
      input  RxD,
      output dataOut, dataValid, frameErr, busy
   );
endinterface

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick: one-clk pulse every DIVISOR clocks.
module uart_rx_tick_gen #(
   parameter int DIVISOR = 326
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign tick = (r_cnt == CNT_W'(DIVISOR - 1));

   // Divider counter, wraps on every tick.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values and simulation matches the synthesized flops.
      if (!rst_n)    r_cnt <= '0;
      else if (tick) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/uart_word_receiver.sv
// 8N2 serial receiver assembling BYTES_PER_WORD bytes (LSB first) into one word.
module uart_word_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ       = 50000000,
   parameter int BAUD           = 9600,
   parameter int OVERSAMPLE     = 16,
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT_BITS   = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   uart_word_receiver_if.slave bus
);
   localparam int DIVISOR  = uart_divisor(CLK_FREQ, BAUD);
   localparam int WORD_W   = 8 * BYTES_PER_WORD;
   localparam int K_W      = $clog2(BYTES_PER_WORD + 1);
   localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
   localparam int TO_W     = $clog2(TO_TICKS + 1);

   logic               w_tick;
   logic               r_rx_meta;
   logic               r_rxs;
   logic [STATE_W-1:0] r_state;
   logic [3:0]         r_sc;
   logic [2:0]         r_bit;
   logic [7:0]         r_shift;
   logic [WORD_W-1:0]  r_word;
   logic [WORD_W-1:0]  w_word_next;
   logic [WORD_W-1:0]  r_data_out;
   logic [K_W-1:0]     r_k;
   logic [TO_W-1:0]    r_to;
   logic               r_valid;
   logic               r_ferr;

   uart_rx_tick_gen #(.DIVISOR(DIVISOR)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= bus.RxD;
         r_rxs     <= r_rx_meta;
      end
   end

   // Partial word with the just-received byte merged into slot k.
   always_comb begin
      // NOTE: assign a full default before the partial update, otherwise the
      // untouched bits would have to hold their value and infer a latch.
      w_word_next               = r_word;
      w_word_next[8*r_k +: 8]   = r_shift;
   end

   // Frame FSM, byte commit, word assembly and inter-byte timeout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sc       <= '0;
         r_bit      <= '0;
         r_k        <= '0;
         r_to       <= '0;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
         // NOTE: data registers are reset as well so a word aborted by reset
         // can never leak into a later commit or onto dataOut.
         r_shift    <= '0;
         r_word     <= '0;
         r_data_out <= '0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;

         // A partial word waiting in IDLE is dropped after TIMEOUT_BITS bit-times.
         if (r_state != IDLE || r_k == '0) begin
            r_to <= '0;
         end else if (w_tick) begin
            if (r_to == TO_W'(TO_TICKS - 1)) begin
               r_to <= '0;
               r_k  <= '0;
            end else begin
               r_to <= r_to + 1'b1;
            end
         end

         if (w_tick) begin
            case (r_state)
               IDLE: begin
                  if (r_rxs == START_BIT) begin
                     r_state <= START;
                     r_sc    <= '0;
                  end
               end
               START: begin
                  // Re-check the line at mid start bit to reject glitches.
                  if (r_sc == 4'd7) begin
                     r_sc <= '0;
                     if (r_rxs == START_BIT) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_sc <= r_sc + 4'd1;
                  end
               end
               DATA: begin
                  r_sc <= r_sc + 4'd1;
                  if (r_sc == 4'd15) begin
                     r_shift[r_bit] <= r_rxs;
                     if (r_bit == 3'(DATA_BITS - 1)) r_state <= STOP1;
                     else                            r_bit   <= r_bit + 3'd1;
                  end
               end
               STOP1: begin
                  r_sc <= r_sc + 4'd1;
                  if (r_sc == 4'd15) begin
                     if (r_rxs != STOP_BIT) begin
                        r_ferr  <= 1'b1;
                        r_k     <= '0;
                        r_state <= IDLE;
                     end else begin
                        r_state <= STOP2;
                     end
                  end
               end
               STOP2: begin
                  r_sc <= r_sc + 4'd1;
                  if (r_sc == 4'd15) begin
                     // Leaving at mid stop2 leaves half a bit to catch a back-to-back start.
                     r_state <= IDLE;
                     if (r_rxs != STOP_BIT) begin
                        r_ferr <= 1'b1;
                        r_k    <= '0;
                     end else begin
                        r_word <= w_word_next;
                        if (r_k == K_W'(BYTES_PER_WORD - 1)) begin
                           r_data_out <= w_word_next;
                           r_valid    <= 1'b1;
                           r_k        <= '0;
                        end else begin
                           r_k <= r_k + 1'b1;
                        end
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.dataOut   = r_data_out;
   assign bus.dataValid = r_valid;
   assign bus.frameErr  = r_ferr;
   assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_word_receiver.sv
// Scoreboard bench for uart_word_receiver: directed 8N2 frames, expected words queued.
module tb_uart_word_receiver;
   import uart_pkg::*;

   // Divisor 2 -> 32 clk per bit keeps the run short.
   localparam int CLK_FREQ = 3200000;
   localparam int BAUD     = 100000;
   localparam int BIT_CLKS = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   uart_word_receiver_if bus ();

   uart_word_receiver #(
      .CLK_FREQ       (CLK_FREQ),
      .BAUD           (BAUD),
      .OVERSAMPLE     (16),
      .BYTES_PER_WORD (4),
      .TIMEOUT_BITS   (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          n_fe  = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every dataValid; tally frameErr pulses.
   always @(negedge clk) begin
      logic [31:0] e;
      if (bus.dataValid || bus.frameErr)
         check("valid_ferr_exclusive", 32'(bus.dataValid & bus.frameErr), 32'd0);
      if (bus.frameErr) n_fe++;
      if (bus.dataValid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", bus.dataOut, 32'hxxxxxxxx);
         end else begin
            e = exp_q.pop_front();
            check("word", bus.dataOut, e);
         end
      end
   end

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop1);
      logic [10:0] frame;
      frame = {STOP_BIT, stop1, b, START_BIT};
      for (int i = 0; i < 11; i++) begin
         bus.RxD = frame[i];
         idle_clks(BIT_CLKS);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fe_base;
      logic [31:0] third;

      bus.RxD = 1'b1;
      rst_n   = 1'b0;
      idle_clks(3);
      check("rst_dataOut",   bus.dataOut, 32'd0);
      check("rst_dataValid", 32'(bus.dataValid), 32'd0);
      check("rst_frameErr",  32'(bus.frameErr), 32'd0);
      check("rst_busy",      32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      idle_clks(2 * BIT_CLKS);

      // Single word, back-to-back bytes.
      exp_q.push_back(32'hDEADBEEF);
      send_word(32'hDEADBEEF);
      idle_clks(40);
      check("t1_pending", exp_q.size(), 32'd0);
      check("t1_frameErr_count", n_fe, 32'd0);
      check("t1_hold", bus.dataOut, 32'hDEADBEEF);

      // Two words with zero idle between frames.
      exp_q.push_back(32'h01234567);
      exp_q.push_back(32'h89ABCDEF);
      send_word(32'h01234567);
      send_word(32'h89ABCDEF);
      idle_clks(40);
      check("t2_pending", exp_q.size(), 32'd0);
      check("t2_dataOut", bus.dataOut, 32'h89ABCDEF);
      check("t2_frameErr_count", n_fe, 32'd0);

      // Start glitch between bytes 2 and 3 must not disturb the byte counter.
      exp_q.push_back(32'h78563412);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      bus.RxD = 1'b0;
      idle_clks(6);
      bus.RxD = 1'b1;
      check("t3_busy_on_glitch", 32'(bus.busy), 32'd1);
      idle_clks(30);
      check("t3_busy_after_glitch", 32'(bus.busy), 32'd0);
      send_byte(8'h56, 1'b1);
      send_byte(8'h78, 1'b1);
      idle_clks(40);
      check("t3_pending", exp_q.size(), 32'd0);
      check("t3_frameErr_count", n_fe, 32'd0);

      // Bad stop1 on the third byte discards the partial word.
      fe_base = n_fe;
      exp_q.push_back(32'h77665544);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      send_byte(8'h77, 1'b1);
      idle_clks(40);
      check("t4_frameErr_count", n_fe - fe_base, 32'd1);
      check("t4_pending", exp_q.size(), 32'd0);
      check("t4_dataOut", bus.dataOut, 32'h77665544);

      // Inter-byte timeout drops 0xAA, 0xBB.
      exp_q.push_back(32'h04030201);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      idle_clks(40 * BIT_CLKS);
      send_word(32'h04030201);
      idle_clks(40);
      check("t5_pending", exp_q.size(), 32'd0);
      check("t5_dataOut", bus.dataOut, 32'h04030201);

      // Reset during bit 4 of the third byte, then a fresh word.
      send_byte(8'h99, 1'b1);
      send_byte(8'h88, 1'b1);
      third   = 32'h00000033;
      bus.RxD = START_BIT;
      idle_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         bus.RxD = third[i];
         idle_clks(BIT_CLKS);
      end
      bus.RxD = third[4];
      idle_clks(BIT_CLKS / 2);
      rst_n = 1'b0;
      idle_clks(1);
      bus.RxD = 1'b1;
      check("t6_rst_dataOut", bus.dataOut, 32'd0);
      check("t6_rst_busy",    32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      idle_clks(2 * 11 * BIT_CLKS);
      exp_q.push_back(32'hCAFEF00D);
      send_word(32'hCAFEF00D);
      idle_clks(40);
      check("t6_pending", exp_q.size(), 32'd0);
      check("t6_dataOut", bus.dataOut, 32'hCAFEF00D);
      check("t6_busy_idle", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_word_receiver.md
Name: uart_word_receiver

Overview:
- Serial receiver for the 32-bit word link.
- Samples RxD at 16x the baud rate. Frames are 8N2: one start bit (0), 8 data bits LSB first, two stop bits (1).
- Four consecutive bytes are assembled into one 32-bit word, least-significant byte first.
- Sits at the far end of the word transmitter and hands each completed word to downstream logic with a one-cycle valid strobe.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit. Fixed at 16; other values are not supported.
- BYTES_PER_WORD, 4: bytes per assembled word.
- TIMEOUT_BITS, 32: idle bit-times between bytes of one word before the partial word is discarded.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- RxD  input  1  asynchronous serial line, idle high.
- dataOut  output  32  last completed word; holds until the next word completes.
- dataValid  output  1  one-cycle pulse when dataOut updates.
- frameErr  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high from start-bit detection until the end of the stop2 sample.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - dataOut=0, dataValid=0, frameErr=0, busy=0.
  - state=IDLE, byte counter=0, synchronizer flops=1, tick divider=0, timeout counter=0.
  - Reset mid-frame abandons the byte and the partial word; nothing is emitted.
- Synchronizer: RxD passes through a 2-flop synchronizer. All decisions use the synchronized value rxs, so latency from RxD to rxs is 2 clk.
- Tick generator:
  - Divisor = CLK_FREQ/(BAUD*16), rounded to nearest (326 at the defaults).
  - Emits a one-clk tick; free-running after reset.
  - All state timing below counts ticks, using a 4-bit sample counter sc.
- State machine:
  - IDLE: on a tick with rxs=0, go to START with sc=0.
  - START:
    - Count ticks; at sc=7 (mid-bit), if rxs=0 go to DATA with sc=0 and bit index=0.
    - If rxs=1 at sc=7, the low was a glitch: return to IDLE with no output.
  - DATA:
    - Every 16 ticks (sc wraps 15→0) sample rxs into shift[bit index], LSB first.
    - After bit 7, go to STOP1.
  - STOP1: sample at the 16-tick point. If rxs=0, pulse frameErr, discard the byte, set byte counter=0, and go to IDLE. Otherwise go to STOP2.
  - STOP2: sample at the 16-tick point.
    - rxs=0: pulse frameErr, discard the byte, set byte counter=0.
    - Otherwise commit the byte.
    - Either way go to IDLE.
- Byte commit:
  - Write the byte into word[8*k+7:8*k], where k is the byte counter, then increment k.
  - When k reaches BYTES_PER_WORD (commit of the 4th byte): dataOut←word, pulse dataValid on the same clk as the commit, and set k=0.
  - The 4th byte therefore appears on dataOut in the clk after its stop2 sample edge.
- Inter-byte timeout:
  - While in IDLE with k≠0, count ticks.
  - At TIMEOUT_BITS*16 ticks, set k=0 and discard the partial word; no flag is raised.
  - The counter clears on leaving IDLE or when k=0.
- Back-to-back frames: a start bit immediately after stop2 must be caught. IDLE is entered at the stop2 mid-sample, so detection slack is about half a bit.
- dataValid and frameErr never pulse in the same clk; a frame error occurs on a discarded byte, never on a commit.
- busy = (state≠IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - State encoding constants: IDLE, START, DATA, STOP1, STOP2.
  - OVERSAMPLE=16 and a function computing the divisor from CLK_FREQ/BAUD.
  - Frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8, STOP_BITS=2. These are shared with the transmitter side.
- One sub-module, uart_rx_tick_gen: parameterized divisor; ports clk, rst_n, tick.
- Synchronizer, FSM, shift register, word assembly and timeout stay in uart_word_receiver.

Test Plan:
- Word 0xDEADBEEF as bytes 0xEF, 0xBE, 0xAD, 0xDE, 8N2, back-to-back at 9600 baud → exactly one dataValid pulse; dataOut=0xDEADBEEF; frameErr never asserted.
- Two consecutive words, 0x01234567 then 0x89ABCDEF, with zero idle between frames → two dataValid pulses, values in order; no byte lost.
- RxD low for 3 tick periods, then high → FSM returns to IDLE; no dataValid or frameErr; byte counter unchanged.
- Bytes 0x11 and 0x22, then a frame 0x33 with stop1 forced to 0, then 0x44, 0x55, 0x66, 0x77 → one frameErr pulse; then dataOut=0x77665544 with one dataValid.
- Bytes 0xAA and 0xBB, then idle for 40 bit-times, then 0x01, 0x02, 0x03, 0x04 → partial word dropped; dataOut=0x04030201.
- rst_n=0 for 1 clk during bit 4 of the third byte of a word, then a full word 0xCAFEF00D → outputs return to reset values; no output from the aborted word; dataOut=0xCAFEF00D after the new word.
